// File: rtl/pong_vga_render.sv
// Pong video back end: VGA raster timing, once-per-frame coordinate shadowing,
// and ball/paddle rendering over a black background.
`timescale 1ns/1ps
module pong_vga_render #(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PAD_W     = 8,
    parameter int unsigned PAD_H     = 48,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [9:0] bx_in,
    input  logic [9:0] by_in,
    input  logic [9:0] p1x_in,
    input  logic [9:0] p1y_in,
    input  logic [9:0] p2x_in,
    input  logic [9:0] p2y_in,
    output logic       busy,
    output logic       frame_tick,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int unsigned CW       = 10;
    localparam int unsigned SW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic          pix_en;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic [CW-1:0] bx, by, p1x, p1y, p2x, p2y;

    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs_next;
    logic          vs_next;
    logic          ball_hit;
    logic          p1_hit;
    logic          p2_hit;
    logic [3:0]    r_next;
    logic [3:0]    g_next;
    logic [3:0]    b_next;

    // Half-open interval test in 11 bits so origins near 1023 cannot wrap to 0.
    function automatic logic in_span(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] org,
                                     input logic [SW-1:0] len);
        logic [SW-1:0] p;
        logic [SW-1:0] o;
        p = {1'b0, pos};
        o = {1'b0, org};
        return (o <= p) && (p < (o + len));
    endfunction

    always_comb begin
        h_last   = (hcnt == CW'(H_TOTAL - 1));
        v_last   = (vcnt == CW'(V_TOTAL - 1));
        active   = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
        hs_next  = !((hcnt >= CW'(HS_START)) && (hcnt < CW'(HS_END)));
        vs_next  = !((vcnt >= CW'(VS_START)) && (vcnt < CW'(VS_END)));
        ball_hit = in_span(hcnt, bx, SW'(BALL_SIZE)) && in_span(vcnt, by, SW'(BALL_SIZE));
        p1_hit   = in_span(hcnt, p1x, SW'(PAD_W)) && in_span(vcnt, p1y, SW'(PAD_H));
        p2_hit   = in_span(hcnt, p2x, SW'(PAD_W)) && in_span(vcnt, p2y, SW'(PAD_H));
    end

    // Colour priority: ball over paddle 1 over paddle 2 over black.
    always_comb begin
        r_next = 4'h0;
        g_next = 4'h0;
        b_next = 4'h0;
        if (active) begin
            if (ball_hit) begin
                r_next = 4'hF;
                g_next = 4'hF;
                b_next = 4'hF;
            end else if (p1_hit) begin
                g_next = 4'hF;
            end else if (p2_hit) begin
                b_next = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pix_en      <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            bx          <= '0;
            by          <= '0;
            p1x         <= '0;
            p1y         <= '0;
            p2x         <= '0;
            p2y         <= '0;
            busy        <= 1'b1;
            frame_tick  <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
        end else begin
            pix_en     <= ~pix_en;
            frame_tick <= 1'b0;
            if (pix_en) begin
                if (h_last) begin
                    hcnt <= '0;
                    vcnt <= v_last ? '0 : vcnt + CW'(1);
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
                // Last pixel of the frame: latch coordinates for the next frame.
                if (h_last && v_last) begin
                    bx         <= bx_in;
                    by         <= by_in;
                    p1x        <= p1x_in;
                    p1y        <= p1y_in;
                    p2x        <= p2x_in;
                    p2y        <= p2y_in;
                    frame_tick <= 1'b1;
                end
                busy        <= (vcnt < CW'(V_ACTIVE));
                vga_hs      <= hs_next;
                vga_vs      <= vs_next;
                vga_blank_n <= active;
                vga_r       <= r_next;
                vga_g       <= g_next;
                vga_b       <= b_next;
            end
        end
    end

endmodule

// File: tb/tb_pong_vga_render.sv
// Bench for pong_vga_render: cycle-exact reference model on a reduced raster,
// plus a one-line timing check on the full 640x480 raster.
`timescale 1ns/1ps
module tb_pong_vga_render;

    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 8;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 4;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int BS = 4, PW = 3, PH = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_big;
    logic [9:0] bx, by, p1x, p1y, p2x, p2y;

    logic       busy, tick, hs, vs, blank_n;
    logic [3:0] r, g, b;
    logic       busy_f, tick_f, hs_f, vs_f, blank_f;
    logic [3:0] r_f, g_f, b_f;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int sh[6] = '{0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    pong_vga_render #(
        .BALL_SIZE(BS), .PAD_W(PW), .PAD_H(PH),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .bx_in(bx), .by_in(by), .p1x_in(p1x), .p1y_in(p1y), .p2x_in(p2x), .p2y_in(p2y),
        .busy(busy), .frame_tick(tick), .vga_hs(hs), .vga_vs(vs), .vga_blank_n(blank_n),
        .vga_r(r), .vga_g(g), .vga_b(b)
    );

    pong_vga_render dut_full (
        .clk_clk(clk), .reset_reset(rst_big),
        .bx_in(bx), .by_in(by), .p1x_in(p1x), .p1y_in(p1y), .p2x_in(p2x), .p2y_in(p2y),
        .busy(busy_f), .frame_tick(tick_f), .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(blank_f),
        .vga_r(r_f), .vga_g(g_f), .vga_b(b_f)
    );

    function automatic bit inside_span(int pos, int org, int len);
        return (org <= pos) && (pos < org + len);
    endfunction

    // Expected {hs,vs,blank_n,r,g,b,busy,frame_tick} after the n-th clock since reset.
    function automatic logic [16:0] model(int nn);
        int p, q, x, y;
        bit e_hs, e_vs, act, e_busy, e_tick;
        logic [11:0] rgb;
        if (nn < 2) return {1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0};
        p      = nn / 2 - 1;
        q      = p % FT;
        x      = q % HT;
        y      = q / HT;
        e_hs   = !(x >= HA + HFP && x < HA + HFP + HSY);
        e_vs   = !(y >= VA + VFP && y < VA + VFP + VSY);
        act    = (x < HA) && (y < VA);
        e_busy = (y < VA);
        e_tick = (nn % (2 * FT) == 0);
        rgb    = 12'h000;
        if (act) begin
            if (inside_span(x, sh[0], BS) && inside_span(y, sh[1], BS))      rgb = 12'hFFF;
            else if (inside_span(x, sh[2], PW) && inside_span(y, sh[3], PH)) rgb = 12'h0F0;
            else if (inside_span(x, sh[4], PW) && inside_span(y, sh[5], PH)) rgb = 12'h00F;
        end
        return {e_hs, e_vs, act, rgb, e_busy, e_tick};
    endfunction

    function automatic logic [9:0] rcoord();
        if ($urandom_range(0, 3) == 0) return 10'($urandom_range(990, 1023));
        return 10'($urandom_range(0, 50));
    endfunction

    task automatic cyc(input logic r_v, input bit rnd);
        int snap[6];
        logic [16:0] exp_v, got;
        rst = r_v;
        if (rnd) begin
            bx = rcoord(); by = rcoord(); p1x = rcoord();
            p1y = rcoord(); p2x = rcoord(); p2y = rcoord();
        end
        snap = '{int'(bx), int'(by), int'(p1x), int'(p1y), int'(p2x), int'(p2y)};
        @(posedge clk);
        if (r_v) begin
            n  = 0;
            sh = '{0, 0, 0, 0, 0, 0};
        end else begin
            n++;
        end
        exp_v = model(n);
        if (!r_v && n >= 2 && (n % (2 * FT) == 0)) sh = snap;
        @(negedge clk);
        got = {hs, vs, blank_n, r, g, b, busy, tick};
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL pixel n=%0d observed=%h expected=%h", n, got, exp_v);
        end
    endtask

    task automatic run(input int cycles, input bit rnd);
        for (int i = 0; i < cycles; i++) cyc(1'b0, rnd);
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int hs_low, blank_hi, white, busy_low, vs_low, ticks, fall1, fall2, guard;
        logic prev_hs;
        rst_big = 1'b1;
        bx = 10'd10; by = 10'd12; p1x = 10'd2; p1y = 10'd5; p2x = 10'd30; p2y = 10'd8;

        // Reset, then two frames of fixed, non-overlapping objects.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        run(4 * FT + 20, 1'b0);

        // Ball overlapping paddle 1: ball wins on the overlap.
        bx = 10'd3; by = 10'd6; p1x = 10'd2; p1y = 10'd4;
        run(4 * FT, 1'b0);

        // Near-wrap origins: ball at x=1020, paddle 2 at y=1000 never drawn.
        bx = 10'd1020; by = 10'd0; p2x = 10'd5; p2y = 10'd1000;
        run(4 * FT, 1'b0);

        // Mid-frame change of bx: visible only after the next load.
        bx = 10'd10; by = 10'd10;
        run(2 * FT + 2 * HT * 12, 1'b0);
        bx = 10'd25;
        run(3 * FT, 1'b0);

        // Inputs churning every clock; only the load-clock values may show.
        run(6 * FT, 1'b1);

        // One-clock reset in the middle of the frame.
        guard = 0;
        while ((((n / 2 - 1) % FT) / HT != 15) && guard < 2 * FT) begin
            cyc(1'b0, 1'b0);
            guard++;
        end
        check("reach_mid_frame", int'(guard < 2 * FT), 1);
        cyc(1'b1, 1'b0);
        run(2 * FT + 50, 1'b1);

        // Full-raster line timing; shadows are zero so ball and paddles sit at (0,0).
        rst_big = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_big = 1'b0;
        hs_low = 0; blank_hi = 0; white = 0; busy_low = 0; vs_low = 0; ticks = 0;
        fall1 = -1; fall2 = -1;
        prev_hs = hs_f;
        for (int e = 1; e <= 3300; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e <= 1600) begin
                if (!hs_f) hs_low++;
                if (blank_f) blank_hi++;
                if ({r_f, g_f, b_f} == 12'hFFF) white++;
            end
            if (!busy_f) busy_low++;
            if (!vs_f) vs_low++;
            if (tick_f) ticks++;
            if (prev_hs && !hs_f) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            prev_hs = hs_f;
        end
        check("full_hs_low_clocks", hs_low, 192);
        check("full_blank_high_clocks", blank_hi, 1280);
        check("full_white_clocks", white, 16);
        check("full_first_hs_fall", fall1, 1314);
        check("full_line_period", fall2 - fall1, 1600);
        check("full_busy_low", busy_low, 0);
        check("full_vs_low", vs_low, 0);
        check("full_frame_tick", ticks, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_vga_render.md
# pong_vga_render

Video back end for the Pong design. It consumes the ball and paddle coordinates published by the Nios system and generates 640x480 at 60 Hz VGA timing from the 50 MHz system clock. It draws the ball and both paddles over a black background. It drives the `busy` flag back to the processor so coordinates are only changed outside active video. Coordinates are shadow-latched once per frame, so a frame never tears.

## Interface
Parameters:
- BALL_SIZE, 8: ball edge length in pixels (square).
- PAD_W, 8: paddle width in pixels.
- PAD_H, 48: paddle height in pixels.

Ports (one clock; reset is synchronous and active-high):
- clk_clk  in  1  50 MHz system clock.
- reset_reset  in  1  synchronous, active-high reset.
- bx_in  in  10  ball left x.
- by_in  in  10  ball top y.
- p1x_in  in  10  paddle 1 left x.
- p1y_in  in  10  paddle 1 top y.
- p2x_in  in  10  paddle 2 left x.
- p2y_in  in  10  paddle 2 top y.
- busy  out  1  high while vcnt < 480 (active lines); feeds the processor busy input.
- frame_tick  out  1  one-clock pulse when a new frame starts (shadow load).
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high during active video.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.

## Operation
- pix_en register toggles every clock. It is 0 in the first clock after reset, so it is 1 on every second clock (25 MHz pixel rate).
- hcnt runs 0..799 and vcnt runs 0..524. Both advance only when pix_en=1. hcnt wraps 799->0, and vcnt increments on that wrap; vcnt wraps 524->0.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Shadow load: when pix_en=1 with hcnt=799 and vcnt=524, all six inputs are copied into shadow registers and frame_tick=1 for that clock.
  - Inputs are ignored at every other time.
  - Shadows reset to 0.
- Hit tests use the current hcnt/vcnt against the shadows. All sums are 11-bit, so coordinates near 1023 never wrap.
  - Ball: bx <= x < bx+BALL_SIZE and by <= y < by+BALL_SIZE.
  - Paddle 1 and paddle 2: px <= x < px+PAD_W and py <= y < py+PAD_H.
- Colour priority: ball white (F,F,F) > paddle 1 green (0,F,0) > paddle 2 blue (0,0,F) > background black.
- Outside the active area, RGB is forced to 0 and vga_blank_n=0.
- busy is registered as (vcnt < 480) and updates on pix_en cycles.
- No state machine beyond the counters. Reset mid-frame immediately returns all counters, shadows and outputs to their reset values, and the next frame starts from (0,0).

## Timing
- Reset values:
  - hcnt=0, vcnt=0, pix_en=0.
  - vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0.
  - busy=1, frame_tick=0.
  - Shadows 0.
- vga_hs, vga_vs, vga_blank_n and RGB are registered. They update only on pix_en=1 clocks and reflect the counter values present on that clock, which gives a one-pixel (2-clock) latency. Sync and colour stay mutually aligned.
- busy falls on the pix_en clock with vcnt=480 and rises on the pix_en clock with vcnt=0.
- A shadow load takes effect on pixel (0,0) of the following frame. An input change on any clock outside the load clock is invisible until the next load.
- Frame period: 800*525*2 = 840000 clocks. Line period: 1600 clocks.

## Test plan
- Reset, then run one line. Required:
  - vga_hs low for exactly 96 pixel periods (192 clocks), starting at the output for hcnt=656.
  - Line period 1600 clocks.
  - vga_blank_n high for 640 pixels.
- Run two frames. Required:
  - vga_vs low for 2 lines (3200 clocks).
  - frame_tick pulses exactly 840000 clocks apart.
  - busy low for 45 lines per frame.
- Set bx=100, by=200 before a load. Required:
  - Pixels x=100..107 on lines 200..207 are white.
  - x=99 and x=108 are black.
- Set p1=(10,100) and ball=(12,110), overlapping. Required:
  - Overlap pixels are white.
  - Remaining paddle pixels x=10..17, y=100..147 are green.
- Change bx mid-frame (vcnt=100). Required: the current frame is unchanged, and the new value appears from the next frame.
- Set bx=1020 and p2y=1000. Required:
  - No wrap artefacts: nothing is drawn at x=0..3.
  - Paddle 2 is never drawn.
- Assert reset at vcnt=300 for 1 clock. Required:
  - Every output returns to its reset value on the next clock.
  - The counters restart at (0,0).
